// File: rtl/pulse_shaper.sv
// Multi-channel pulse shaper: each channel turns a level or edge trigger into a
// fixed-length pulse followed by an optional holdoff, with retrigger and drop flagging.
module pulse_shaper #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] sig,
  input  logic [CNT_W-1:0]    cfg_len,
  input  logic [CNT_W-1:0]    cfg_hold,
  input  logic                cfg_edge,
  input  logic                cfg_retrig,
  output logic [CHANNELS-1:0] osig,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] drop
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t              r_state     [CHANNELS];
  state_t              w_state_nxt [CHANNELS];
  logic [CNT_W-1:0]    r_cnt       [CHANNELS];
  logic [CNT_W-1:0]    w_cnt_nxt   [CHANNELS];
  logic [CHANNELS-1:0] r_sig_d;
  logic [CHANNELS-1:0] r_osig;
  logic [CHANNELS-1:0] r_busy;
  logic [CHANNELS-1:0] r_drop;
  logic [CHANNELS-1:0] w_trig;
  logic [CHANNELS-1:0] w_drop_nxt;
  logic [CNT_W-1:0]    w_len_m1;
  logic [CNT_W-1:0]    w_hold_m1;

  // A zero length behaves as a one-cycle pulse.
  assign w_len_m1  = (cfg_len == '0) ? '0 : cfg_len - CNT_W'(1);
  assign w_hold_m1 = cfg_hold - CNT_W'(1);
  assign w_trig    = cfg_edge ? (sig & ~r_sig_d) : sig;

  assign osig = r_osig;
  assign busy = r_busy;
  assign drop = r_drop;

  // Per-channel next-state, counter and drop decode.
  always_comb begin
    w_drop_nxt = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        ST_IDLE: begin
          if (w_trig[i]) begin
            w_state_nxt[i] = ST_PULSE;
            w_cnt_nxt[i]   = w_len_m1;
          end
        end
        ST_PULSE: begin
          if (w_trig[i] && cfg_retrig) begin
            w_cnt_nxt[i] = w_len_m1;
          end else begin
            w_drop_nxt[i] = w_trig[i];
            if (r_cnt[i] != '0) begin
              w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
            end else if (cfg_hold != '0) begin
              w_state_nxt[i] = ST_HOLD;
              w_cnt_nxt[i]   = w_hold_m1;
            end else begin
              w_state_nxt[i] = ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          w_drop_nxt[i] = w_trig[i];
          if (r_cnt[i] != '0) begin
            w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
          end else begin
            w_state_nxt[i] = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt[i] = ST_IDLE;
          w_cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs; sig_d resets high to mask a stale edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sig_d <= '1;
      r_osig  <= '0;
      r_busy  <= '0;
      r_drop  <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_sig_d <= sig;
      r_drop  <= w_drop_nxt;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
        r_osig[i]  <= (w_state_nxt[i] == ST_PULSE);
        r_busy[i]  <= (w_state_nxt[i] != ST_IDLE);
      end
    end
  end

endmodule
